// File: rtl/lidar_bbox_pkg.sv
// Shared definitions for the LiDAR bounding-box accumulator: default widths,
// the {x, y, z} packing used by the downstream unpack stage, and FSM states.
package lidar_bbox_pkg;

   localparam int COORD_W_DEFAULT = 16;

   // Fixed slice positions of the default 48-bit packed word
   localparam int X_MSB = 47;
   localparam int X_LSB = 32;
   localparam int Y_MSB = 31;
   localparam int Y_LSB = 16;
   localparam int Z_MSB = 15;
   localparam int Z_LSB = 0;

   // Axis index within a packed word, in units of COORD_W
   localparam int AXIS_X = 2;
   localparam int AXIS_Y = 1;
   localparam int AXIS_Z = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

endpackage

// File: rtl/bbox_axis_minmax.sv
// Registered signed running minimum and maximum for one coordinate axis.
// load seeds both registers with the value; update widens them as needed.
module bbox_axis_minmax
   import lidar_bbox_pkg::*;
#(
   parameter int W = COORD_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         update,
   input  logic [W-1:0] value,
   output logic [W-1:0] min_val,
   output logic [W-1:0] max_val
);

   always_ff @(posedge clk) begin
      if (rst) begin
         min_val <= '0;
         max_val <= '0;
      end else if (load) begin
         min_val <= value;
         max_val <= value;
      end else if (update) begin
         if ($signed(value) < $signed(min_val)) min_val <= value;
         if ($signed(value) > $signed(max_val)) max_val <= value;
      end
   end

endmodule

// File: rtl/lidar_bbox_accumulator.sv
// Accumulates one cluster of points into an axis-aligned box {min, max, count}.
// Define LIDAR_BBOX_MIN_POINTS_FILTER_EN to discard clusters smaller than MIN_POINTS.
module lidar_bbox_accumulator
   import lidar_bbox_pkg::*;
#(
   parameter int COORD_W    = COORD_W_DEFAULT,
   parameter int CNT_W      = 12,
   parameter int MIN_POINTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3*COORD_W-1:0] point_in,
   input  logic                 point_valid,
   input  logic                 point_last,
   output logic                 point_ready,
   output logic [3*COORD_W-1:0] box_min_out,
   output logic [3*COORD_W-1:0] box_max_out,
   output logic [CNT_W-1:0]     box_count,
   output logic                 box_valid,
   input  logic                 box_ready,
   output logic                 box_dropped
);

`ifdef LIDAR_BBOX_MIN_POINTS_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] final_count;
   logic             accept;
   logic             load;
   logic             update;
   logic             drop;

   assign accept = point_valid && point_ready;
   assign load   = accept && (state == IDLE);
   assign update = accept && (state == ACCUM);

   // Count including the point being accepted now; saturates at all-ones
   assign final_count = load ? CNT_W'(1)
                      : ((count == '1) ? count : count + CNT_W'(1));

   assign drop = FILTER_EN && accept && point_last && (int'(final_count) < MIN_POINTS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         if (accept) count <= final_count;
      end
   end

   always_comb begin
      state_next  = state;
      point_ready = 1'b0;
      box_valid   = 1'b0;
      case (state)
         IDLE, ACCUM: begin
            point_ready = 1'b1;
            if (accept) begin
               if (point_last) state_next = drop ? IDLE : OUTPUT;
               else            state_next = ACCUM;
            end
         end
         OUTPUT: begin
            box_valid = 1'b1;
            if (box_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign box_count = count;

   bbox_axis_minmax #(.W(COORD_W)) u_axis_x (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .update  (update),
      .value   (point_in[AXIS_X*COORD_W +: COORD_W]),
      .min_val (box_min_out[AXIS_X*COORD_W +: COORD_W]),
      .max_val (box_max_out[AXIS_X*COORD_W +: COORD_W])
   );

   bbox_axis_minmax #(.W(COORD_W)) u_axis_y (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .update  (update),
      .value   (point_in[AXIS_Y*COORD_W +: COORD_W]),
      .min_val (box_min_out[AXIS_Y*COORD_W +: COORD_W]),
      .max_val (box_max_out[AXIS_Y*COORD_W +: COORD_W])
   );

   bbox_axis_minmax #(.W(COORD_W)) u_axis_z (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .update  (update),
      .value   (point_in[AXIS_Z*COORD_W +: COORD_W]),
      .min_val (box_min_out[AXIS_Z*COORD_W +: COORD_W]),
      .max_val (box_max_out[AXIS_Z*COORD_W +: COORD_W])
   );

`ifdef LIDAR_BBOX_MIN_POINTS_FILTER_EN
   logic dropped_q;

   always_ff @(posedge clk) begin
      if (rst) dropped_q <= 1'b0;
      else     dropped_q <= drop;
   end

   assign box_dropped = dropped_q;
`else
   assign box_dropped = 1'b0;
`endif

endmodule

// File: tb/tb_lidar_bbox_accumulator.sv
// Self-checking bench for lidar_bbox_accumulator: directed cases plus random
// clusters compared against a plain min/max/count model of each cluster.
module tb_lidar_bbox_accumulator;
   import lidar_bbox_pkg::*;

   localparam int MIN_PTS = 4;
   localparam int CNT_MAX = 4095;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] point_in;
   logic        point_valid;
   logic        point_last;
   logic        point_ready;
   logic [47:0] box_min_out;
   logic [47:0] box_max_out;
   logic [11:0] box_count;
   logic        box_valid;
   logic        box_ready;
   logic        box_dropped;

   int checks = 0;
   int errors = 0;
   int qx[$];
   int qy[$];
   int qz[$];

   always #5 clk = ~clk;

   lidar_bbox_accumulator #(.COORD_W(16), .CNT_W(12), .MIN_POINTS(MIN_PTS)) dut (
      .clk         (clk),
      .rst         (rst),
      .point_in    (point_in),
      .point_valid (point_valid),
      .point_last  (point_last),
      .point_ready (point_ready),
      .box_min_out (box_min_out),
      .box_max_out (box_max_out),
      .box_count   (box_count),
      .box_valid   (box_valid),
      .box_ready   (box_ready),
      .box_dropped (box_dropped)
   );

   function automatic logic [47:0] pack(input int x, input int y, input int z);
      logic [47:0] w;
      w[X_MSB:X_LSB] = x[15:0];
      w[Y_MSB:Y_LSB] = y[15:0];
      w[Z_MSB:Z_LSB] = z[15:0];
      return w;
   endfunction

   // Expected box of the points recorded in qx/qy/qz
   task automatic model_box(output logic [47:0] mn, output logic [47:0] mx, output int cnt);
      int lo[3];
      int hi[3];
      lo = '{qx[0], qy[0], qz[0]};
      hi = lo;
      for (int i = 1; i < qx.size(); i++) begin
         if (qx[i] < lo[0]) lo[0] = qx[i];
         if (qy[i] < lo[1]) lo[1] = qy[i];
         if (qz[i] < lo[2]) lo[2] = qz[i];
         if (qx[i] > hi[0]) hi[0] = qx[i];
         if (qy[i] > hi[1]) hi[1] = qy[i];
         if (qz[i] > hi[2]) hi[2] = qz[i];
      end
      mn  = pack(lo[0], lo[1], lo[2]);
      mx  = pack(hi[0], hi[1], hi[2]);
      cnt = (qx.size() > CNT_MAX) ? CNT_MAX : qx.size();
   endtask

   function automatic int rnd_coord();
      case ($urandom_range(0, 5))
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   task automatic clear_model();
      qx.delete();
      qy.delete();
      qz.delete();
   endtask

   // Presents one point; it is accepted on the following rising edge
   task automatic drive_point(input int x, input int y, input int z, input bit last, input bit gap);
      if (gap) begin
         @(negedge clk);
         point_valid = 1'b0;
      end
      @(negedge clk);
      point_valid = 1'b1;
      point_in    = pack(x, y, z);
      point_last  = last;
      @(posedge clk);
      qx.push_back(x);
      qy.push_back(y);
      qz.push_back(z);
   endtask

   task automatic end_points();
      @(negedge clk);
      point_valid = 1'b0;
      point_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      point_valid = 1'b0;
      point_last = 1'b0;
      point_in = '0;
      box_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (point_ready !== 1'b1 || box_valid !== 1'b0 || box_dropped !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b valid=%b dropped=%b, want 1 0 0", point_ready, box_valid, box_dropped);
      end
      checks++;
      if (box_min_out !== 48'h0 || box_max_out !== 48'h0 || box_count !== 12'h0) begin
         errors++;
         $display("FAIL reset_data: min=%h max=%h cnt=%0d, want all 0", box_min_out, box_max_out, box_count);
      end
      rst = 1'b0;
   endtask

`ifndef LIDAR_BBOX_MIN_POINTS_FILTER_EN
   task automatic test_single();
      clear_model();
      drive_point(5, -3, 100, 1'b1, 1'b0);
      end_points();
      checks++;
      if (box_valid !== 1'b1 || box_min_out !== pack(5, -3, 100) || box_max_out !== pack(5, -3, 100) || box_count !== 12'd1) begin
         errors++;
         $display("FAIL single: valid=%b min=%h max=%h cnt=%0d, want 1 %h %h 1", box_valid, box_min_out, box_max_out, box_count, pack(5, -3, 100), pack(5, -3, 100));
      end
      box_ready = 1'b1;
      @(negedge clk);
      box_ready = 1'b0;
      checks++;
      if (box_valid !== 1'b0 || box_dropped !== 1'b0) begin
         errors++;
         $display("FAIL single_xfer: valid=%b dropped=%b, want 0 0", box_valid, box_dropped);
      end
   endtask

   task automatic test_three();
      clear_model();
      drive_point(1, 2, 3, 1'b0, 1'b0);
      drive_point(-4, 10, 0, 1'b0, 1'b0);
      drive_point(7, -8, 3, 1'b1, 1'b0);
      end_points();
      checks++;
      if (box_valid !== 1'b1 || box_min_out !== pack(-4, -8, 0) || box_max_out !== pack(7, 10, 3) || box_count !== 12'd3) begin
         errors++;
         $display("FAIL three: valid=%b min=%h max=%h cnt=%0d, want 1 %h %h 3", box_valid, box_min_out, box_max_out, box_count, pack(-4, -8, 0), pack(7, 10, 3));
      end
      box_ready = 1'b1;
      @(negedge clk);
      box_ready = 1'b0;
   endtask

   task automatic test_extremes();
      clear_model();
      drive_point(-32768, 32767, 0, 1'b0, 1'b0);
      drive_point(32767, -32768, -1, 1'b1, 1'b0);
      end_points();
      checks++;
      if (box_min_out !== pack(-32768, -32768, -1) || box_max_out !== pack(32767, 32767, 0) || box_count !== 12'd2) begin
         errors++;
         $display("FAIL extremes: min=%h max=%h cnt=%0d, want %h %h 2", box_min_out, box_max_out, box_count, pack(-32768, -32768, -1), pack(32767, 32767, 0));
      end
      box_ready = 1'b1;
      @(negedge clk);
      box_ready = 1'b0;
   endtask

   task automatic test_hold();
      clear_model();
      drive_point(10, 20, 30, 1'b0, 1'b0);
      drive_point(-10, 25, 29, 1'b1, 1'b0);
      @(negedge clk);
      point_valid = 1'b1;
      point_last  = 1'b1;
      point_in    = pack(-999, -999, -999);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (box_valid !== 1'b1 || point_ready !== 1'b0 || box_min_out !== pack(-10, 20, 29) || box_max_out !== pack(10, 25, 30) || box_count !== 12'd2) begin
            errors++;
            $display("FAIL hold[%0d]: valid=%b ready=%b min=%h max=%h cnt=%0d, want 1 0 %h %h 2", k, box_valid, point_ready, box_min_out, box_max_out, box_count, pack(-10, 20, 29), pack(10, 25, 30));
         end
         @(negedge clk);
      end
      point_valid = 1'b0;
      box_ready = 1'b1;
      @(negedge clk);
      box_ready = 1'b0;
      checks++;
      if (box_valid !== 1'b0 || point_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_xfer: valid=%b ready=%b, want 0 1", box_valid, point_ready);
      end
   endtask

   task automatic test_back_to_back();
      box_ready = 1'b1;
      clear_model();
      drive_point(1, 1, 1, 1'b0, 1'b0);
      drive_point(2, 2, 2, 1'b1, 1'b0);
      @(negedge clk);
      point_valid = 1'b1;
      point_last  = 1'b1;
      point_in    = pack(9, -9, 9);
      checks++;
      if (box_valid !== 1'b1 || point_ready !== 1'b0 || box_min_out !== pack(1, 1, 1) || box_max_out !== pack(2, 2, 2) || box_count !== 12'd2) begin
         errors++;
         $display("FAIL b2b_first: valid=%b ready=%b min=%h max=%h cnt=%0d, want 1 0 %h %h 2", box_valid, point_ready, box_min_out, box_max_out, box_count, pack(1, 1, 1), pack(2, 2, 2));
      end
      @(negedge clk);
      checks++;
      if (box_valid !== 1'b0 || point_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_dead: valid=%b ready=%b, want 0 1", box_valid, point_ready);
      end
      @(negedge clk);
      point_valid = 1'b0;
      point_last  = 1'b0;
      checks++;
      if (box_valid !== 1'b1 || box_min_out !== pack(9, -9, 9) || box_max_out !== pack(9, -9, 9) || box_count !== 12'd1) begin
         errors++;
         $display("FAIL b2b_second: valid=%b min=%h max=%h cnt=%0d, want 1 %h %h 1", box_valid, box_min_out, box_max_out, box_count, pack(9, -9, 9), pack(9, -9, 9));
      end
      @(negedge clk);
      box_ready = 1'b0;
   endtask
`else
   task automatic test_filter();
      clear_model();
      for (int i = 0; i < 3; i++) drive_point(i, -i, 2 * i, i == 2, 1'b0);
      end_points();
      checks++;
      if (box_dropped !== 1'b1 || box_valid !== 1'b0 || point_ready !== 1'b1) begin
         errors++;
         $display("FAIL filter_drop: dropped=%b valid=%b ready=%b, want 1 0 1", box_dropped, box_valid, point_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (box_dropped !== 1'b0 || box_valid !== 1'b0) begin
            errors++;
            $display("FAIL filter_after[%0d]: dropped=%b valid=%b, want 0 0", k, box_dropped, box_valid);
         end
      end
      clear_model();
      for (int i = 0; i < 4; i++) drive_point(i, -i, 2 * i, i == 3, 1'b0);
      end_points();
      checks++;
      if (box_valid !== 1'b1 || box_dropped !== 1'b0 || box_count !== 12'd4 || box_min_out !== pack(0, -3, 0) || box_max_out !== pack(3, 0, 6)) begin
         errors++;
         $display("FAIL filter_keep: valid=%b dropped=%b cnt=%0d min=%h max=%h, want 1 0 4 %h %h", box_valid, box_dropped, box_count, box_min_out, box_max_out, pack(0, -3, 0), pack(3, 0, 6));
      end
      box_ready = 1'b1;
      @(negedge clk);
      box_ready = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      int n;
      logic [47:0] mn;
      logic [47:0] mx;
      int cnt;
`ifdef LIDAR_BBOX_MIN_POINTS_FILTER_EN
      n = MIN_PTS;
`else
      n = 1;
`endif
      clear_model();
      drive_point(100, 200, 300, 1'b0, 1'b0);
      drive_point(-100, -200, -300, 1'b0, 1'b0);
      @(negedge clk);
      point_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (box_valid !== 1'b0 || point_ready !== 1'b1 || box_count !== 12'd0 || box_min_out !== 48'h0 || box_max_out !== 48'h0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b ready=%b cnt=%0d min=%h max=%h, want 0 1 0 0 0", box_valid, point_ready, box_count, box_min_out, box_max_out);
      end
      clear_model();
      for (int i = 0; i < n; i++) drive_point(7, 8, 9, i == n - 1, 1'b0);
      end_points();
      model_box(mn, mx, cnt);
      checks++;
      if (box_valid !== 1'b1 || box_min_out !== mn || box_max_out !== mx || int'(box_count) != cnt) begin
         errors++;
         $display("FAIL reset_recover: valid=%b min=%h max=%h cnt=%0d, want 1 %h %h %0d", box_valid, box_min_out, box_max_out, box_count, mn, mx, cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (box_valid !== 1'b0 || box_count !== 12'd0) begin
         errors++;
         $display("FAIL reset_output: valid=%b cnt=%0d, want 0 0", box_valid, box_count);
      end
   endtask

   task automatic test_saturation();
      logic [47:0] mn;
      logic [47:0] mx;
      int cnt;
      int n;
      n = CNT_MAX + 5;
      clear_model();
      for (int i = 0; i < n; i++) drive_point(rnd_coord(), rnd_coord(), rnd_coord(), i == n - 1, 1'b0);
      end_points();
      model_box(mn, mx, cnt);
      checks++;
      if (box_valid !== 1'b1 || int'(box_count) != cnt || box_min_out !== mn || box_max_out !== mx) begin
         errors++;
         $display("FAIL saturation: valid=%b cnt=%0d min=%h max=%h, want 1 %0d %h %h", box_valid, box_count, box_min_out, box_max_out, cnt, mn, mx);
      end
      box_ready = 1'b1;
      @(negedge clk);
      box_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [47:0] mn;
      logic [47:0] mx;
      int cnt;
      int n;
      int delay;
      for (int c = 0; c < 40; c++) begin
         n = $urandom_range(1, 8);
         clear_model();
         for (int i = 0; i < n; i++)
            drive_point(rnd_coord(), rnd_coord(), rnd_coord(), i == n - 1, $urandom_range(0, 3) == 0);
         end_points();
         model_box(mn, mx, cnt);
`ifdef LIDAR_BBOX_MIN_POINTS_FILTER_EN
         if (n < MIN_PTS) begin
            checks++;
            if (box_dropped !== 1'b1 || box_valid !== 1'b0) begin
               errors++;
               $display("FAIL rand_drop[%0d]: dropped=%b valid=%b, want 1 0", c, box_dropped, box_valid);
            end
            continue;
         end
`endif
         checks++;
         if (box_valid !== 1'b1 || box_dropped !== 1'b0 || box_min_out !== mn || box_max_out !== mx || int'(box_count) != cnt) begin
            errors++;
            $display("FAIL rand_box[%0d]: valid=%b dropped=%b min=%h max=%h cnt=%0d, want 1 0 %h %h %0d", c, box_valid, box_dropped, box_min_out, box_max_out, box_count, mn, mx, cnt);
         end
         delay = $urandom_range(0, 3);
         for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            checks++;
            if (box_valid !== 1'b1 || point_ready !== 1'b0 || box_min_out !== mn || box_max_out !== mx) begin
               errors++;
               $display("FAIL rand_hold[%0d]: valid=%b ready=%b min=%h max=%h", c, box_valid, point_ready, box_min_out, box_max_out);
            end
         end
         box_ready = 1'b1;
         @(negedge clk);
         box_ready = 1'b0;
         checks++;
         if (box_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_xfer[%0d]: valid=%b, want 0", c, box_valid);
         end
      end
   endtask

   initial begin
      test_reset();
`ifndef LIDAR_BBOX_MIN_POINTS_FILTER_EN
      test_single();
      test_three();
      test_extremes();
      test_hold();
      test_back_to_back();
`else
      test_filter();
`endif
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
